// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave for the processor READ/WRITE/ADDR bus.
//
// Writes land in the array on every edge WRITE is high (READ low). A read is
// accepted from IDLE and returns data exactly READ_LATENCY rising edges later.
// The data is then held for as long as READ stays high on the same address.
// Out-of-range accesses and READ+WRITE collisions raise sticky error flags.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   ADDR       word address
//   DATA_IN    write data
//   READ       read request (level, held by the processor)
//   WRITE      write request (level)
//   DATA_OUT   registered read data, never high-Z
//   DATA_VALID DATA_OUT belongs to the current read
//   BUSY       read in flight (RD_WAIT)
//   ADDR_ERR   sticky, any access at ADDR >= 2**DEPTH_LOG2
//   PROT_ERR   sticky, READ and WRITE sampled high together
//
// Optional build macro MEM_RESPONDER_STATS_EN adds two outputs:
//   RD_COUNT   16-bit wrapping count of read completions
//   WR_COUNT   16-bit wrapping count of write edges (out-of-range included)
//
// READ_LATENCY must lie in 1..4.

module mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 26,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  READ,
    input  logic                  WRITE,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    output logic                  BUSY,
    output logic                  ADDR_ERR,
    output logic                  PROT_ERR
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]           RD_COUNT,
    output logic [15:0]           WR_COUNT
`endif
);

    localparam int          DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [2:0]  LAT_M1 = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   addr_lat, addr_lat_nxt;
    logic [DATA_WIDTH-1:0]   data_out_nxt;
    logic                    valid_nxt, busy_nxt, addr_err_nxt, prot_err_nxt;
    logic                    mem_we;
    logic                    start_rd, do_wr;
    logic                    addr_ok, lat_ok;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> DEPTH_LOG2) == '0;
    endfunction

    assign addr_ok = in_range(ADDR);
    assign lat_ok  = in_range(addr_lat);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_lat_nxt = addr_lat;
        data_out_nxt = DATA_OUT;
        valid_nxt    = DATA_VALID;
        busy_nxt     = BUSY;
        addr_err_nxt = ADDR_ERR;
        prot_err_nxt = PROT_ERR;
        mem_we       = 1'b0;
        start_rd     = 1'b0;
        do_wr        = 1'b0;

        if (READ && WRITE) begin
            // Collision wins over everything: no access, back to IDLE.
            prot_err_nxt = 1'b1;
            state_nxt    = IDLE;
            valid_nxt    = 1'b0;
            busy_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (READ) begin
                        start_rd = 1'b1;
                    end else if (WRITE) begin
                        do_wr = 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (!READ) begin
                        // Abort; a write presented on the same edge is served.
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        do_wr     = WRITE;
                    end else if (cnt == 3'd0) begin
                        data_out_nxt = lat_ok ? mem[addr_lat[DEPTH_LOG2-1:0]] : '0;
                        valid_nxt    = 1'b1;
                        busy_nxt     = 1'b0;
                        state_nxt    = RD_HOLD;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                RD_HOLD: begin
                    if (!READ) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        do_wr     = WRITE;
                    end else if (ADDR != addr_lat) begin
                        start_rd = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end

        if (do_wr) begin
            if (addr_ok) begin
                mem_we = 1'b1;
            end else begin
                addr_err_nxt = 1'b1;
            end
        end

        if (start_rd) begin
            addr_lat_nxt = ADDR;
            cnt_nxt      = LAT_M1;
            state_nxt    = RD_WAIT;
            busy_nxt     = 1'b1;
            valid_nxt    = 1'b0;
            if (!addr_ok) begin
                addr_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            ADDR_ERR   <= 1'b0;
            PROT_ERR   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            DATA_OUT   <= data_out_nxt;
            DATA_VALID <= valid_nxt;
            BUSY       <= busy_nxt;
            ADDR_ERR   <= addr_err_nxt;
            PROT_ERR   <= prot_err_nxt;
        end
    end

    // Latched address is only meaningful while a read is open; no reset needed.
    always_ff @(posedge CLK) begin
        addr_lat <= addr_lat_nxt;
    end

    // Storage survives reset; writes are gated off while reset is held.
    always_ff @(posedge CLK) begin
        if (mem_we && RST) begin
            mem[ADDR[DEPTH_LOG2-1:0]] <= DATA_IN;
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    logic rd_done;
    assign rd_done = (state != RD_HOLD) && (state_nxt == RD_HOLD);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD_COUNT <= 16'd0;
            WR_COUNT <= 16'd0;
        end else begin
            if (rd_done) RD_COUNT <= RD_COUNT + 16'd1;
            if (do_wr)   WR_COUNT <= WR_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int DL  = 10;
    localparam int LAT = 2;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATA_IN;
    logic          READ;
    logic          WRITE;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_VALID;
    logic          BUSY;
    logic          ADDR_ERR;
    logic          PROT_ERR;
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0]   RD_COUNT;
    logic [15:0]   WR_COUNT;
`endif

    mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .READ_LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .READ(READ), .WRITE(WRITE), .DATA_OUT(DATA_OUT),
        .DATA_VALID(DATA_VALID), .BUSY(BUSY),
        .ADDR_ERR(ADDR_ERR), .PROT_ERR(PROT_ERR)
`ifdef MEM_RESPONDER_STATS_EN
        , .RD_COUNT(RD_COUNT), .WR_COUNT(WR_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    // Reference model: plain storage keyed by address plus expected flags/counts.
    logic [DW-1:0] mem_model [int];
    logic          exp_addr_err, exp_prot_err;
    logic [15:0]   exp_rd, exp_wr;

    function automatic bit oor(input logic [AW-1:0] a);
        return a >= (1 << DL);
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset;
        READ = 0; WRITE = 0; ADDR = '0; DATA_IN = '0;
        #2 RST = 0;
        exp_addr_err = 0; exp_prot_err = 0; exp_rd = 0; exp_wr = 0;
        tick; tick;
        RST = 1;
        tick;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ADDR = a; DATA_IN = d; WRITE = 1; READ = 0;
        tick;
        WRITE = 0;
        exp_wr++;
        if (oor(a)) exp_addr_err = 1;
        else mem_model[int'(a)] = d;
    endtask

    // Raise READ on a, count edges until DATA_VALID; READ is left high.
    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d,
                             output int lat, output bit busy_ok);
        ADDR = a; READ = 1; WRITE = 0;
        busy_ok = 1; lat = 0;
        tick;
        if (oor(a)) exp_addr_err = 1;
        while (lat < 8) begin
            if (DATA_VALID || !BUSY) busy_ok = 0;
            tick;
            lat++;
            if (DATA_VALID) break;
        end
        if (BUSY) busy_ok = 0;
        d = DATA_OUT;
        if (DATA_VALID) exp_rd++;
        else lat = -1;
    endtask

    task automatic release_read;
        READ = 0;
        tick;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (oor(a)) return '0;
        return mem_model[int'(a)];
    endfunction

    task automatic test_reset;
        RST = 0; READ = 0; WRITE = 0; ADDR = '0; DATA_IN = '0;
        exp_addr_err = 0; exp_prot_err = 0; exp_rd = 0; exp_wr = 0;
        tick; tick;
        RST = 1;
        tick;
        checks++; if (DATA_OUT !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", DATA_OUT); end
        checks++; if ({DATA_VALID, BUSY, ADDR_ERR, PROT_ERR} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {DATA_VALID, BUSY, ADDR_ERR, PROT_ERR}); end
`ifdef MEM_RESPONDER_STATS_EN
        checks++; if ({RD_COUNT, WR_COUNT} !== 32'd0) begin fails++; $display("FAIL reset_stats: got %h/%h want 0/0", RD_COUNT, WR_COUNT); end
`endif
    endtask

    task automatic test_basic_rw;
        logic [DW-1:0] d; int lat; bit bok;
        do_write(26'h010, 32'hDEADBEEF);
        do_write(26'h011, 32'h12345678);
        do_write(26'h000, 32'hA5A50000);
        read_word(26'h010, d, lat, bok);
        checks++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_data: got %h want deadbeef", d); end
        checks++; if (!bok) begin fails++; $display("FAIL basic_busy: got 0 want 1 during wait"); end
    endtask

    task automatic test_hold_addr_change;
        logic [DW-1:0] d; int lat; bit bok;
        bit stable = 1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (!DATA_VALID || DATA_OUT !== 32'hDEADBEEF) stable = 0;
        end
        checks++; if (!stable) begin fails++; $display("FAIL hold_stable: got %h/%b want deadbeef/1", DATA_OUT, DATA_VALID); end
        read_word(26'h011, d, lat, bok);
        checks++; if (lat !== LAT) begin fails++; $display("FAIL restart_latency: got %0d want %0d", lat, LAT); end
        checks++; if (d !== 32'h12345678) begin fails++; $display("FAIL restart_data: got %h want 12345678", d); end
        checks++; if (!bok) begin fails++; $display("FAIL restart_valid_drop: valid/busy wrong during restart"); end
        release_read;
        checks++; if (DATA_VALID !== 1'b0 || DATA_OUT !== 32'h12345678) begin fails++; $display("FAIL release: got %h/%b want 12345678/0", DATA_OUT, DATA_VALID); end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] d; int lat; bit bok;
        do_write(26'h400, 32'hFFFFFFFF);
        checks++; if (ADDR_ERR !== 1'b1) begin fails++; $display("FAIL oor_write_flag: got %b want 1", ADDR_ERR); end
        read_word(26'h000, d, lat, bok);
        checks++; if (d !== 32'hA5A50000) begin fails++; $display("FAIL oor_no_alias: got %h want a5a50000", d); end
        release_read;
        apply_reset;
        read_word(26'h400, d, lat, bok);
        checks++; if (lat !== LAT || d !== '0) begin fails++; $display("FAIL oor_read: got %h lat %0d want 0 lat %0d", d, lat, LAT); end
        checks++; if (ADDR_ERR !== 1'b1) begin fails++; $display("FAIL oor_read_flag: got %b want 1", ADDR_ERR); end
        release_read;
    endtask

    task automatic test_prot_err;
        logic [DW-1:0] d; int lat; bit bok;
        ADDR = 26'h010; DATA_IN = 32'h0BADF00D; READ = 1; WRITE = 1;
        tick;
        READ = 0; WRITE = 0;
        exp_prot_err = 1;
        checks++; if ({PROT_ERR, DATA_VALID, BUSY} !== 3'b100) begin fails++; $display("FAIL prot_idle: got %b want 100", {PROT_ERR, DATA_VALID, BUSY}); end
        read_word(26'h010, d, lat, bok);
        checks++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL prot_no_write: got %h want deadbeef", d); end
        release_read;
        ADDR = 26'h011; READ = 1;
        tick;
        WRITE = 1;
        tick;
        READ = 0; WRITE = 0;
        checks++; if ({DATA_VALID, BUSY} !== 2'b00) begin fails++; $display("FAIL prot_wait_abort: got %b want 00", {DATA_VALID, BUSY}); end
        tick; tick; tick;
        checks++; if (DATA_VALID !== 1'b0 || PROT_ERR !== 1'b1) begin fails++; $display("FAIL prot_sticky: got v%b p%b want v0 p1", DATA_VALID, PROT_ERR); end
    endtask

    task automatic test_reset_mid_read;
        logic [DW-1:0] d; int lat; bit bok;
        read_word(26'h010, d, lat, bok);
        release_read;
        ADDR = 26'h011; READ = 1;
        tick;
        #2 RST = 0;
        #1;
        checks++; if ({DATA_OUT, DATA_VALID, BUSY, ADDR_ERR, PROT_ERR} !== '0) begin fails++; $display("FAIL async_reset: got %h %b%b%b%b want all 0", DATA_OUT, DATA_VALID, BUSY, ADDR_ERR, PROT_ERR); end
        READ = 0;
        exp_addr_err = 0; exp_prot_err = 0; exp_rd = 0; exp_wr = 0;
        tick;
        RST = 1;
        tick;
        read_word(26'h011, d, lat, bok);
        checks++; if (d !== 32'h12345678) begin fails++; $display("FAIL post_reset_data: got %h want 12345678", d); end
        release_read;
    endtask

    task automatic test_random;
        logic [DW-1:0] d; int lat; bit bok;
        logic [AW-1:0] a, b;
        apply_reset;
        for (int i = 0; i < 16; i++) do_write(AW'(i), $urandom);
        for (int it = 0; it < 40; it++) begin
            a = AW'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: do_write(a, $urandom);
                1, 3: begin
                    if ($urandom_range(0, 2) == 0) a = AW'($urandom) | AW'(26'h400);
                    read_word(a, d, lat, bok);
                    checks++; if (lat !== LAT || d !== model_rd(a) || !bok) begin fails++; $display("FAIL rand_read: addr %h got %h lat %0d want %h lat %0d", a, d, lat, model_rd(a), LAT); end
                    release_read;
                end
                2: do_write(AW'($urandom) | AW'(26'h400), $urandom);
                4: begin
                    b = AW'($urandom_range(0, 15));
                    ADDR = a; READ = 1;
                    tick;
                    READ = 0; WRITE = 1; ADDR = b; DATA_IN = $urandom;
                    tick;
                    WRITE = 0;
                    mem_model[int'(b)] = DATA_IN;
                    exp_wr++;
                    checks++; if ({DATA_VALID, BUSY} !== 2'b00) begin fails++; $display("FAIL rand_abort_write: got %b want 00", {DATA_VALID, BUSY}); end
                end
                default: begin
                    ADDR = a; READ = 1;
                    tick;
                    READ = 0;
                    tick; tick;
                    checks++; if (DATA_VALID !== 1'b0) begin fails++; $display("FAIL rand_abort: got valid %b want 0", DATA_VALID); end
                end
            endcase
            checks++; if (ADDR_ERR !== exp_addr_err || PROT_ERR !== exp_prot_err) begin fails++; $display("FAIL rand_flags: got %b%b want %b%b", ADDR_ERR, PROT_ERR, exp_addr_err, exp_prot_err); end
        end
`ifdef MEM_RESPONDER_STATS_EN
        checks++; if (RD_COUNT !== exp_rd || WR_COUNT !== exp_wr) begin fails++; $display("FAIL rand_stats: got %h/%h want %h/%h", RD_COUNT, WR_COUNT, exp_rd, exp_wr); end
`endif
    endtask

`ifdef MEM_RESPONDER_STATS_EN
    task automatic test_stats;
        logic [DW-1:0] d; int lat; bit bok;
        apply_reset;
        for (int i = 0; i < 3; i++) begin
            read_word(AW'(i), d, lat, bok);
            release_read;
        end
        do_write(26'h020, 32'h1);
        do_write(26'h021, 32'h2);
        checks++; if (RD_COUNT !== 16'd3 || WR_COUNT !== 16'd2) begin fails++; $display("FAIL stats_basic: got %0d/%0d want 3/2", RD_COUNT, WR_COUNT); end
        ADDR = 26'h020; DATA_IN = 32'h1; WRITE = 1;
        for (int i = 0; i < 65533; i++) begin
            tick;
            exp_wr++;
        end
        WRITE = 0;
        checks++; if (WR_COUNT !== exp_wr || exp_wr !== 16'hFFFF) begin fails++; $display("FAIL stats_preload: got %h want ffff", WR_COUNT); end
        do_write(26'h020, 32'h1);
        checks++; if (WR_COUNT !== 16'h0000) begin fails++; $display("FAIL stats_wrap: got %h want 0000", WR_COUNT); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic_rw;
        test_hold_addr_change;
        test_out_of_range;
        test_prot_err;
        test_reset_mid_read;
        test_random;
`ifdef MEM_RESPONDER_STATS_EN
        test_stats;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
